divider_32fp: RTL and testbench

//  Iterative IEEE-754 binary32 divider, companion to the FP32 multiplier. Computes quotient_o = a_i / b_i

---
 rtl/divider_32fp.sv | 197 +++++++++++++++++++
 tb/tb_divider_32fp.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_32fp.sv
// Iterative binary32 divider: restoring mantissa division, truncating rounding,
// denormals flushed to zero, exception flags pulsed alongside done_o.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start_i, operands latched on acceptance
// S_UNPACK | classify operands, special results go straight to S_DONE
// S_DIVIDE | resolve STEPS_PER_CYCLE quotient bits per cycle (25 total)
// S_NORM   | normalise quotient, detect exponent overflow/underflow
// S_DONE   | registered result and flags presented for one cycle
module divider_32fp #(
    // Must divide 25 evenly (1, 5 or 25).
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] quotient_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        nan_o,
    output logic        infinit_o,
    output logic        div_zero_o,
    output logic        overflow_o,
    output logic        underflow_o
);

    localparam int DIV_CYCLES = 25 / STEPS_PER_CYCLE;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_DIVIDE,
        S_NORM,
        S_DONE
    } state_t;

    state_t      state, state_next;
    logic [31:0] a_r, b_r;
    logic [24:0] rem, rem_next;
    logic [24:0] quo, quo_next;
    logic [9:0]  exp_r;
    logic        sign_r;
    logic [4:0]  cnt;

    // Operand classification and unpacked fields, from the latched operands.
    logic [7:0]  ea, eb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        sign_u;
    logic [9:0]  exp_u;
    logic [23:0] mb;

    assign ea     = a_r[30:23];
    assign eb     = b_r[30:23];
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
    assign sign_u = a_r[31] ^ b_r[31];
    assign exp_u  = {2'b00, ea} - {2'b00, eb} + 10'd127;
    assign mb     = {1'b1, b_r[22:0]};

    // Restoring division steps chained combinationally within one cycle.
    always_comb begin
        rem_next = rem;
        quo_next = quo;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            if (rem_next >= {1'b0, mb}) begin
                rem_next = (rem_next - {1'b0, mb}) << 1;
                quo_next = {quo_next[23:0], 1'b1};
            end else begin
                rem_next = rem_next << 1;
                quo_next = {quo_next[23:0], 1'b0};
            end
        end
    end

    // Normalisation of the finished quotient.
    logic [22:0] mant_n;
    logic [9:0]  exp_n;

    assign mant_n = quo[24] ? quo[23:1] : quo[22:0];
    assign exp_n  = quo[24] ? exp_r : exp_r - 10'd1;

    // Result and flag selection for the cycle that enters S_DONE.
    // Flag vector order: {nan, infinit, div_zero, overflow, underflow}.
    logic        special;
    logic [31:0] res_next;
    logic [4:0]  flags_next;

    always_comb begin
        special    = 1'b0;
        res_next   = 32'd0;
        flags_next = 5'd0;
        if (state == S_UNPACK) begin
            if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
                special    = 1'b1;
                res_next   = QNAN;
                flags_next = 5'b10000;
            end else if (a_inf) begin
                special    = 1'b1;
                res_next   = {sign_u, INF_MAG};
                flags_next = 5'b01000;
            end else if (b_zero) begin
                special    = 1'b1;
                res_next   = {sign_u, INF_MAG};
                flags_next = 5'b00100;
            end else if (a_zero || b_inf) begin
                special    = 1'b1;
                res_next   = {sign_u, 31'd0};
            end
        end else if (state == S_NORM) begin
            if ($signed(exp_n) >= 10'sd255) begin
                res_next   = {sign_r, INF_MAG};
                flags_next = 5'b00010;
            end else if ($signed(exp_n) <= 10'sd0) begin
                res_next   = {sign_r, 31'd0};
                flags_next = 5'b00001;
            end else begin
                res_next   = {sign_r, exp_n[7:0], mant_n};
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start_i) state_next = S_UNPACK;
            S_UNPACK: state_next = special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (cnt == 5'd0) state_next = S_NORM;
            S_NORM:   state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // State register, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            rem         <= 25'd0;
            quo         <= 25'd0;
            exp_r       <= 10'd0;
            sign_r      <= 1'b0;
            cnt         <= 5'd0;
            quotient_o  <= 32'd0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            nan_o       <= 1'b0;
            infinit_o   <= 1'b0;
            div_zero_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            state  <= state_next;
            busy_o <= (state_next != S_IDLE);
            done_o <= (state_next == S_DONE);
            if (state_next == S_DONE) begin
                quotient_o <= res_next;
                {nan_o, infinit_o, div_zero_o, overflow_o, underflow_o} <= flags_next;
            end else begin
                {nan_o, infinit_o, div_zero_o, overflow_o, underflow_o} <= 5'd0;
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        a_r <= a_i;
                        b_r <= b_i;
                    end
                end
                S_UNPACK: begin
                    rem    <= {2'b01, a_r[22:0]};
                    quo    <= 25'd0;
                    exp_r  <= exp_u;
                    sign_r <= sign_u;
                    cnt    <= 5'(DIV_CYCLES - 1);
                end
                S_DIVIDE: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32fp.sv
// Scoreboard bench for divider_32fp: directed vectors push expected result,
// flags and done cycle; monitors pop and compare on every done_o pulse.
module tb_divider_32fp;

    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_NAN  = 5'b10000;
    localparam logic [4:0] F_INF  = 5'b01000;
    localparam logic [4:0] F_DZ   = 5'b00100;
    localparam logic [4:0] F_OV   = 5'b00010;
    localparam logic [4:0] F_UN   = 5'b00001;

    typedef struct {
        logic [31:0] q;
        logic [4:0]  f;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk, rst_n;
    logic        start, start5;
    logic [31:0] a, b, a5, b5;
    logic [31:0] quotient, quotient5;
    logic        busy, done, nan, inf, dz, ov, un;
    logic        busy5, done5, nan5, inf5, dz5, ov5, un5;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t sb5[$];

    divider_32fp dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b),
        .quotient_o(quotient), .busy_o(busy), .done_o(done), .nan_o(nan),
        .infinit_o(inf), .div_zero_o(dz), .overflow_o(ov), .underflow_o(un)
    );

    divider_32fp #(.STEPS_PER_CYCLE(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .start_i(start5), .a_i(a5), .b_i(b5),
        .quotient_o(quotient5), .busy_o(busy5), .done_o(done5), .nan_o(nan5),
        .infinit_o(inf5), .div_zero_o(dz5), .overflow_o(ov5), .underflow_o(un5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string tag, input logic [31:0] gq, input logic [4:0] gf,
                           input int gc, input exp_t e);
        checks++;
        if (gq !== e.q || gf !== e.f || gc != e.cyc) begin
            errors++;
            $display("FAIL %s %s: got q=%h flags=%b cyc=%0d, want q=%h flags=%b cyc=%0d",
                     tag, e.name, gq, gf, gc, e.q, e.f, e.cyc);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Monitor for the default instance.
    initial forever begin
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cyc=%0d, want none", cyc);
            end else begin
                compare("dut", quotient, {nan, inf, dz, ov, un}, cyc, sb.pop_front());
            end
        end else if ({nan, inf, dz, ov, un} !== 5'd0) begin
            checks++;
            errors++;
            $display("FAIL flag_without_done: got flags=%b, want 00000", {nan, inf, dz, ov, un});
        end
    end

    // Monitor for the five-steps-per-cycle instance.
    initial forever begin
        @(posedge clk);
        #1;
        if (done5 === 1'b1) begin
            if (sb5.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done5: got done at cyc=%0d, want none", cyc);
            end else begin
                compare("dut5", quotient5, {nan5, inf5, dz5, ov5, un5}, cyc, sb5.pop_front());
            end
        end
    end

    // Issue one op; the done pulse is observed just after edge t+lat-1,
    // i.e. it is the value sampled at edge t+lat.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] qv,
                         input logic [4:0] fv, input int lat, input string nm, input bit hold);
        exp_t e;
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        e.q = qv;
        e.f = fv;
        e.cyc = cyc + lat - 1;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] qv,
                       input logic [4:0] fv, input int lat, input string nm);
        issue(ia, ib, qv, fv, lat, nm, 1'b0);
        wait_empty();
    endtask

    initial begin
        exp_t e5;
        int   n;
        rst_n = 1'b0;
        start = 1'b0;
        start5 = 1'b0;
        a = 32'd0;
        b = 32'd0;
        a5 = 32'd0;
        b5 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_flags", {27'd0, nan, inf, dz, ov, un}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 6/2 with busy window check
        issue(32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, 28, "6/2", 1'b0);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_empty();
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("busy_after_done", {31'd0, busy}, 32'd0);

        run(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, F_NONE, 28, "1/3");
        run(32'hBF800000, 32'h40400000, 32'hBEAAAAAA, F_NONE, 28, "-1/3");
        run(32'hBF800000, 32'h00000000, 32'hFF800000, F_DZ,    2, "-1/0");
        run(32'h00000000, 32'h00000000, 32'h7FC00000, F_NAN,   2, "0/0");
        run(32'h7F800000, 32'h7F800000, 32'h7FC00000, F_NAN,   2, "inf/inf");
        run(32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_NAN,   2, "nan/1");
        run(32'h7F800000, 32'hC0000000, 32'hFF800000, F_INF,   2, "inf/-2");
        run(32'h40000000, 32'h7F800000, 32'h00000000, F_NONE,  2, "2/inf");
        run(32'h7F000000, 32'h3E800000, 32'h7F800000, F_OV,   28, "overflow");
        run(32'h00800000, 32'h40000000, 32'h00000000, F_UN,   28, "underflow");
        run(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, F_NONE, 28, "1/3_again");

        // start held high throughout: exactly one done, no restart afterwards
        issue(32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, 28, "held_start", 1'b1);
        wait_empty();
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("held_start_idle", {31'd0, busy}, 32'd0);

        // reset in the middle of an operation
        @(negedge clk);
        a = 32'h40C00000;
        b = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_quotient", quotient, 32'd0);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        run(32'hBF800000, 32'h40400000, 32'hBEAAAAAA, F_NONE, 28, "after_reset");

        // five quotient bits per cycle
        @(negedge clk);
        a5 = 32'h40C00000;
        b5 = 32'h40000000;
        start5 = 1'b1;
        @(posedge clk);
        #1;
        start5 = 1'b0;
        e5.q = 32'h40400000;
        e5.f = F_NONE;
        e5.cyc = cyc + 8 - 1;
        e5.name = "6/2_steps5";
        sb5.push_back(e5);
        n = 0;
        while (sb5.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb5.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout5: got %0d pending results, want 0", sb5.size());
            sb5.delete();
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
